writeback_unit: RTL and testbench
=================================

# writeback_unit

Final pipeline stage, directly downstream of the memory stage. Selects the load result or the ALU result as the write-back value and writes it into the 8-entry architectural register file. Serves two combinational read ports to decode, with same-cycle write bypass. Also publishes a registered forwarding record, counts retired instructions, and latches a halt condition.

## Interface
- DATA_W, 16, datapath and register width
- NREGS, 8, register count (index = instr[7:5])
- CNT_W, 32, width of retired/cycle counters
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- iswb  in  1  instruction writes a register (from memory stage)
- isld  in  1  instruction is a load (from memory stage)
- instr  in  16  instruction word aligned with iswb/isld
- aluresult  in  16  ALU result aligned with instr
- ldresult  in  16  load data aligned with instr
- rs_a  in  3  read port A index
- rs_b  in  3  read port B index
- rd_data_a  out  16  register[rs_a], bypassed
- rd_data_b  out  16  register[rs_b], bypassed
- wb_fwd  out  20  registered forwarding record {valid, data[15:0], rd[2:0]}
- retired_count  out  32  non-NOP instructions retired
- cycle_count  out  32  cycles since reset, frozen once halted
- halted  out  1  HALT retired

## Operation
- wb_data = isld ? ldresult : aluresult. rd = instr[7:5].
- NOP: instr == 16'h0000. HALT: instr[15:12] == 4'hF.
- Write enable: we = iswb & ~halted & (instr != 0).
  - When we is high, regs[rd] <= wb_data at the clock edge.
  - All 8 registers are writable; there is no hardwired zero.
- Read ports (combinational): rd_data_x = (we && rs_x == rd) ? wb_data : regs[rs_x].
  - Both ports may address the same register.
  - Both ports may hit the bypass in the same cycle.
- Forwarding record, updated every cycle: wb_fwd <= {we, wb_data, rd} when we is high, else 20'h0.
- retired_count:
  - Increments by 1 each cycle with ~halted and instr != 0.
  - Counting is independent of iswb, so stores and branches are counted.
  - Wraps modulo 2^CNT_W.
- cycle_count: increments each cycle while ~halted; wraps modulo 2^CNT_W.
- Halt:
  - On a cycle with ~halted and HALT: retired_count increments, halted <= 1.
  - A HALT with iswb=1 still writes its register that same cycle.
  - From the next cycle: no register writes, no counting, wb_fwd forced to 0.
  - halted is sticky until reset.
- State machine, 2 states:
  - RUN → HALTED on HALT retire.
  - HALTED → RUN only on reset.

## Timing
- Reset values, applied on the first edge with reset=1:
  - All regs = 0.
  - wb_fwd = 20'h0.
  - retired_count = 0, cycle_count = 0, halted = 0.
- While reset is high:
  - Writes are suppressed.
  - rd_data_x returns the (zeroed) register contents; bypass is disabled.
- Reset mid-operation, including while halted: takes effect on that edge and discards the in-flight write.
- Write latency:
  - Data written at edge N is readable from regs after N.
  - In cycle N-1 the same value is visible through the bypass, so there is zero-cycle read-after-write.
- wb_fwd latency: 1 cycle after the write-back inputs.
- Inputs must be stable before the edge; no handshake and no backpressure. One instruction is accepted per cycle.
- Back-to-back writes to the same rd: the last one wins. The bypass always reflects the current cycle's write only.

## Test plan
- Reset, then read all 8 regs → every rd_data = 0, wb_fwd = 0, counters 0, halted = 0.
- iswb=1, isld=0, instr=16'h10A0 (rd=5), aluresult=16'h1234, rs_a=5 → rd_data_a=16'h1234 in the same cycle; wb_fwd=20'h891A5 next cycle; regs[5]=16'h1234 afterwards.
- iswb=1, isld=1, instr rd=3, aluresult=16'hDEAD, ldresult=16'hBEEF, rs_a=rs_b=3 → both ports return 16'hBEEF; regs[3]=16'hBEEF.
- iswb=0 store-like instr=16'h2000 → no register change, wb_fwd=0, retired_count +1; instr=0 with iswb=1 → no write, no count.
- HALT instr=16'hF0E0 with iswb=1, aluresult=16'h0077 → regs[7]=16'h0077 and halted=1. Following writes are ignored, counters frozen, wb_fwd stays 0.
- Assert reset while halted with pending iswb → all state cleared, halted=0, and the pending write is not performed.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage. Picks the load or ALU result,
// writes it into the 8-entry register file, and serves two read ports to
// decode with a same-cycle write bypass. It also publishes a registered
// forwarding record, counts retired instructions and cycles, and latches
// a sticky halt.
module writeback_unit #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iswb,
    input  logic                      isld,
    input  logic [15:0]               instr,
    input  logic [DATA_W-1:0]         aluresult,
    input  logic [DATA_W-1:0]         ldresult,
    input  logic [$clog2(NREGS)-1:0]  rs_a,
    input  logic [$clog2(NREGS)-1:0]  rs_b,
    output logic [DATA_W-1:0]         rd_data_a,
    output logic [DATA_W-1:0]         rd_data_b,
    output logic [DATA_W+3:0]         wb_fwd,
    output logic [CNT_W-1:0]          retired_count,
    output logic [CNT_W-1:0]          cycle_count,
    output logic                      halted
);

    localparam int IDX_W = $clog2(NREGS);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] wb_data;
    logic [IDX_W-1:0]  rd;
    logic              is_nop;
    logic              is_halt;
    logic              retire;
    logic              we;

    assign wb_data = isld ? ldresult : aluresult;
    assign rd      = instr[5 +: IDX_W];
    assign is_nop  = (instr == 16'h0000);
    assign is_halt = (instr[15:12] == 4'hF);

    // Halt FSM next state plus the qualified retire and write-enable strobes;
    // the write enable is also gated by reset so reset cycles neither write nor bypass.
    always_comb begin
        state_next = state;
        halted     = 1'b0;
        retire     = 1'b0;
        we         = 1'b0;
        case (state)
            RUN: begin
                retire = ~is_nop;
                we     = iswb & ~is_nop & ~reset;
                if (is_halt) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Halt state register; only reset leaves HALTED.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Register file write; a reset edge clears everything and drops the in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[rd] <= wb_data;
        end
    end

    // Forwarding record and the retired/cycle counters, all frozen once halted.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_fwd        <= '0;
            retired_count <= '0;
            cycle_count   <= '0;
        end else begin
            wb_fwd <= we ? {1'b1, wb_data, rd} : '0;
            if (retire) begin
                retired_count <= retired_count + CNT_W'(1);
            end
            if (state == RUN) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

    // Combinational read ports with same-cycle bypass of the current write.
    always_comb begin
        rd_data_a = (we && (rs_a == rd)) ? wb_data : regs[rs_a];
        rd_data_b = (we && (rs_b == rd)) ? wb_data : regs[rs_b];
    end

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed checks with hand-computed values, then a
// randomized run compared every cycle against a behavioural model.
module tb_writeback_unit;

    logic        clk;
    logic        reset;
    logic        iswb;
    logic        isld;
    logic [15:0] instr;
    logic [15:0] aluresult;
    logic [15:0] ldresult;
    logic [2:0]  rs_a;
    logic [2:0]  rs_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [19:0] wb_fwd;
    logic [31:0] retired_count;
    logic [31:0] cycle_count;
    logic        halted;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    logic [15:0] m_regs [8];
    logic [19:0] m_fwd;
    logic [31:0] m_ret;
    logic [31:0] m_cyc;
    bit          m_halted;

    writeback_unit #(.DATA_W(16), .NREGS(8), .CNT_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .iswb(iswb),
        .isld(isld),
        .instr(instr),
        .aluresult(aluresult),
        .ldresult(ldresult),
        .rs_a(rs_a),
        .rs_b(rs_b),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .wb_fwd(wb_fwd),
        .retired_count(retired_count),
        .cycle_count(cycle_count),
        .halted(halted)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit wb, input bit ld, input logic [15:0] ins,
                                 input logic [15:0] alu, input logic [15:0] ldv,
                                 input logic [2:0] a, input logic [2:0] b);
        reset     = r;
        iswb      = wb;
        isld      = ld;
        instr     = ins;
        aluresult = alu;
        ldresult  = ldv;
        rs_a      = a;
        rs_b      = b;
    endtask

    // Value the instruction currently presented would write, and whether it writes.
    function automatic bit modelWrites();
        return !reset && iswb && !m_halted && (instr != 16'h0000);
    endfunction

    function automatic logic [15:0] modelData();
        return isld ? ldresult : aluresult;
    endfunction

    function automatic logic [15:0] modelRead(input logic [2:0] idx);
        if (modelWrites() && idx == instr[7:5]) return modelData();
        return m_regs[idx];
    endfunction

    // Advance the model by one rising edge using the inputs held across it.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            foreach (m_regs[i]) m_regs[i] = 16'h0;
            m_fwd    = 20'h0;
            m_ret    = 0;
            m_cyc    = 0;
            m_halted = 0;
        end else begin
            if (modelWrites()) begin
                m_regs[instr[7:5]] = modelData();
                m_fwd = {1'b1, modelData(), instr[7:5]};
            end else begin
                m_fwd = 20'h0;
            end
            if (!m_halted) begin
                if (instr != 16'h0000) m_ret = m_ret + 1;
                m_cyc = m_cyc + 1;
                if (instr[15:12] == 4'hF) m_halted = 1;
            end
        end
        #1;
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("rd_data_a", 32'(rd_data_a), 32'(modelRead(rs_a)));
            checkOutput("rd_data_b", 32'(rd_data_b), 32'(modelRead(rs_b)));
            checkOutput("wb_fwd", 32'(wb_fwd), 32'(m_fwd));
            checkOutput("retired_count", retired_count, m_ret);
            checkOutput("cycle_count", cycle_count, m_cyc);
            checkOutput("halted", 32'(halted), 32'(m_halted));
        end
    end

    initial begin
        logic [15:0] ins;
        applyStimulus(1, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
        tick();
        check_en = 1;

        // Reset state: every register reads zero, counters clear.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 16'h0, 16'h0, 16'h0, 3'(i), 3'(7 - i));
            @(negedge clk);
            checkOutput("lit_reset_a", 32'(rd_data_a), 32'h0);
            checkOutput("lit_reset_b", 32'(rd_data_b), 32'h0);
            if (i == 0) begin
                checkOutput("lit_reset_fwd", 32'(wb_fwd), 32'h0);
                checkOutput("lit_reset_ret", retired_count, 32'h0);
                checkOutput("lit_reset_cyc", cycle_count, 32'h0);
                checkOutput("lit_reset_halt", 32'(halted), 32'h0);
            end
            tick();
        end

        // ALU write with same-cycle bypass, then forwarding record.
        applyStimulus(0, 1, 0, 16'h10A0, 16'h1234, 16'h0, 3'd5, 3'd0);
        @(negedge clk);
        checkOutput("lit_bypass_alu", 32'(rd_data_a), 32'h1234);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd5, 3'd5);
        @(negedge clk);
        checkOutput("lit_fwd_alu", 32'(wb_fwd), 32'h891A5);
        checkOutput("lit_reg5", 32'(rd_data_b), 32'h1234);
        tick();

        // Load write: both ports bypass the load data.
        applyStimulus(0, 1, 1, 16'h0060, 16'hDEAD, 16'hBEEF, 3'd3, 3'd3);
        @(negedge clk);
        checkOutput("lit_ld_a", 32'(rd_data_a), 32'hBEEF);
        checkOutput("lit_ld_b", 32'(rd_data_b), 32'hBEEF);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd3, 3'd5);
        @(negedge clk);
        checkOutput("lit_reg3", 32'(rd_data_a), 32'hBEEF);
        tick();

        // Store-like instruction counts but does not write; NOP with iswb does nothing.
        applyStimulus(0, 0, 0, 16'h2000, 16'h9999, 16'h0, 3'd0, 3'd0);
        tick();
        applyStimulus(0, 1, 0, 16'h0000, 16'hFFFF, 16'h0, 3'd0, 3'd0);
        @(negedge clk);
        checkOutput("lit_store_fwd", 32'(wb_fwd), 32'h0);
        checkOutput("lit_store_ret", retired_count, 32'd3);
        checkOutput("lit_nop_nobypass", 32'(rd_data_a), 32'h0);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0);
        @(negedge clk);
        checkOutput("lit_nop_ret", retired_count, 32'd3);
        checkOutput("lit_nop_fwd", 32'(wb_fwd), 32'h0);
        tick();

        // HALT writes its register, then everything freezes.
        applyStimulus(0, 1, 0, 16'hF0E0, 16'h0077, 16'h0, 3'd7, 3'd7);
        @(negedge clk);
        checkOutput("lit_halt_bypass", 32'(rd_data_a), 32'h0077);
        tick();
        applyStimulus(0, 1, 0, 16'h10A0, 16'hAAAA, 16'h0, 3'd5, 3'd7);
        @(negedge clk);
        checkOutput("lit_halted", 32'(halted), 32'h1);
        checkOutput("lit_halt_ret", retired_count, 32'd4);
        checkOutput("lit_halt_nobypass", 32'(rd_data_a), 32'h1234);
        checkOutput("lit_reg7", 32'(rd_data_b), 32'h0077);
        tick();
        applyStimulus(0, 1, 0, 16'h10A0, 16'hAAAA, 16'h0, 3'd5, 3'd7);
        @(negedge clk);
        checkOutput("lit_halt_fwd", 32'(wb_fwd), 32'h0);
        checkOutput("lit_halt_reg5", 32'(rd_data_a), 32'h1234);
        checkOutput("lit_halt_ret2", retired_count, 32'd4);
        tick();

        // Reset while halted with a pending write: bypass off, write dropped.
        applyStimulus(1, 1, 0, 16'h10A0, 16'h5555, 16'h0, 3'd5, 3'd5);
        @(negedge clk);
        checkOutput("lit_rst_nobypass", 32'(rd_data_a), 32'h1234);
        tick();
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd5, 3'd7);
        @(negedge clk);
        checkOutput("lit_rst_reg5", 32'(rd_data_a), 32'h0);
        checkOutput("lit_rst_halted", 32'(halted), 32'h0);
        checkOutput("lit_rst_ret", retired_count, 32'h0);
        checkOutput("lit_rst_cyc", cycle_count, 32'h0);
        tick();

        // Randomized run with occasional HALTs and resets.
        for (int n = 0; n < 3000; n++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ins = 16'h0000;
            else if ($urandom_range(0, 79) == 0) ins[15:12] = 4'hF;
            else if (ins[15:12] == 4'hF) ins[15:12] = 4'($urandom_range(0, 14));
            applyStimulus($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom), ins,
                          16'($urandom), 16'($urandom),
                          ($urandom_range(0, 1) == 0) ? ins[7:5] : 3'($urandom),
                          ($urandom_range(0, 2) == 0) ? ins[7:5] : 3'($urandom));
            tick();
        end

        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
